// File: rtl/y_mul_div.sv
// Iterative radix-2 multiply / restoring divide unit with a start/done handshake.
// Optional two's-complement MULH/DIV/REM support is enabled by defining YMULDIV_SIGNED_EN.
module y_mul_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             ex
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    acc_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] z_q;
    logic             ex_q;
    logic             sgn_q;
    logic             neg_a_q;
    logic             neg_b_q;

    logic [AW-1:0]    acc_d;
    logic [WIDTH-1:0] opa_d;
    logic [WIDTH-1:0] opb_d;
    logic [AW-1:0]    fix_acc;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             neg_a_d;
    logic             neg_b_d;
    logic             sgn_d;

    // MUL/DIV results live in the low half, MULH/REM in the high half
    function automatic logic [WIDTH-1:0] sel(input logic hi, input logic [AW-1:0] v);
        return hi ? v[AW-1:WIDTH] : v[WIDTH-1:0];
    endfunction

`ifdef YMULDIV_SIGNED_EN
    // MUL is sign-agnostic in its low half, so only MULH/DIV/REM take magnitudes
    always_comb begin
        sgn_d   = op[2];
        neg_a_d = op[2] && (op[1:0] != 2'b00) && a[WIDTH-1];
        neg_b_d = op[2] && (op[1:0] != 2'b00) && b[WIDTH-1];
        a_mag   = neg_a_d ? -a : a;
        b_mag   = neg_b_d ? -b : b;
    end

    always_comb begin
        fix_acc = acc_q;
        if (op_q[1]) begin
            if (neg_a_q)
                fix_acc[AW-1:WIDTH] = -acc_q[AW-1:WIDTH];
            if (neg_a_q ^ neg_b_q)
                fix_acc[WIDTH-1:0] = -acc_q[WIDTH-1:0];
        end else if (neg_a_q ^ neg_b_q) begin
            fix_acc = -acc_q;
        end
    end
`else
    logic unused_op2;
    assign unused_op2 = op[2];

    always_comb begin
        sgn_d   = 1'b0;
        neg_a_d = 1'b0;
        neg_b_d = 1'b0;
        a_mag   = a;
        b_mag   = b;
        fix_acc = acc_q;
    end
`endif

    // One iteration: shift-add for multiply, shift/trial-subtract for divide
    always_comb begin
        logic [WIDTH:0] sum;
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        logic           ge;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum     = '0;
        shifted = '0;
        diff    = '0;
        ge      = 1'b0;
        if (!op_q[1]) begin
            sum   = opb_q[0] ? ({1'b0, acc_q[AW-1:WIDTH]} + {1'b0, opa_q})
                             : {1'b0, acc_q[AW-1:WIDTH]};
            acc_d = {sum, acc_q[WIDTH-1:1]};
            opb_d = opb_q >> 1;
        end else begin
            shifted = {acc_q[AW-1:WIDTH], opa_q[WIDTH-1]};
            diff    = shifted - {1'b0, opb_q};
            ge      = shifted >= {1'b0, opb_q};
            acc_d   = {(ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
            opa_d   = opa_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= '0;
            ex_q    <= 1'b0;
            sgn_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op[1:0];
                        acc_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        busy_q  <= 1'b1;
                        sgn_q   <= sgn_d;
                        neg_a_q <= neg_a_d;
                        neg_b_q <= neg_b_d;
                        opa_q   <= a_mag;
                        opb_q   <= b_mag;
                        if (op[1] && (b == '0)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            ex_q    <= 1'b1;
                            z_q     <= op[0] ? a : '1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        if (sgn_q) begin
                            state_q <= S_FIX;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            ex_q    <= 1'b0;
                            z_q     <= sel(op_q[0], acc_d);
                        end
                    end
                end
                S_FIX: begin
                    acc_q   <= fix_acc;
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    ex_q    <= 1'b0;
                    z_q     <= sel(op_q[0], fix_acc);
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;
    assign ex   = ex_q;

endmodule

// File: tb/tb_y_mul_div.sv
// Scoreboard bench for y_mul_div (WIDTH=32): directed vectors, monitor checks z/ex/latency on done.
module tb_y_mul_div;

    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_MULH = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_REM  = 3'b011;
`ifdef YMULDIV_SIGNED_EN
    localparam int LS = 34;
`else
    localparam int LS = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] z;
    logic        ex;

    typedef struct {
        logic [31:0] z;
        logic        ex;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    y_mul_div #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .z(z), .ex(ex)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done, checks busy while an op is in flight
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                exp_t e;
                chk("done_single_pulse", 64'(prev_done), 64'(0));
                if (sbq.size() == 0) begin
                    chk("spurious_done", 64'(1), 64'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("z", 64'(z), 64'(e.z));
                    chk("ex", 64'(ex), 64'(e.ex));
                    chk("latency", 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
                end
            end else if (sbq.size() > 0) begin
                chk("busy_inflight", 64'(busy), 64'(1));
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ez, input logic eex, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        if (push) begin
            e.z       = ez;
            e.ex      = eex;
            e.lat     = lat;
            e.acc_cyc = cyc;
            sbq.push_back(e);
        end
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = o ^ 3'b011;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sbq.size() == 0) break;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", 64'(sbq.size()), 64'(0));
            sbq.delete();
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ez, input logic eex, input int lat);
        issue(o, av, bv, ez, eex, lat, 1'b1);
        wait_drain();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_z", 64'(z), 64'(0));
        chk("rst_ex", 64'(ex), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned directed vectors
        run(OP_MUL,  32'd7,        32'd6,        32'd42,        1'b0, 33);
        run(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  1'b0, 33);
        run(OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  1'b0, 33);
        run(OP_MULH, 32'h80000000, 32'd4,        32'd2,         1'b0, 33);
        run(OP_DIV,  32'd100,      32'd7,        32'd14,        1'b0, 33);
        run(OP_REM,  32'd100,      32'd7,        32'd2,         1'b0, 33);
        run(OP_DIV,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,  1'b0, 33);
        run(OP_REM,  32'd7,        32'd100,      32'd7,         1'b0, 33);
        run(OP_DIV,  32'd3,        32'd7,        32'd0,         1'b0, 33);
        run(OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF,  1'b1, 1);
        run(OP_REM,  32'd5,        32'd0,        32'd5,         1'b1, 1);
        run(3'b110,  32'd100,      32'd7,        32'd14,        1'b0, LS);
`ifdef YMULDIV_SIGNED_EN
        run(3'b101,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,  1'b0, 34);
        run(3'b110,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  1'b0, 34);
        run(3'b111,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  1'b0, 34);
        run(3'b110,  32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1'b0, 34);
        run(3'b111,  32'h80000000, 32'hFFFFFFFF, 32'h00000000,  1'b0, 34);
        run(3'b100,  32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6,  1'b0, 34);
        run(3'b111,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9,  1'b1, 1);
`else
        run(3'b101,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  1'b0, 33);
        run(3'b111,  32'd100,      32'd7,        32'd2,         1'b0, 33);
`endif

        // start while busy and during the DONE cycle must be ignored
        issue(OP_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 33, 1'b1);
        repeat (9) @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        chk("ign_done_seen", 64'(done), 64'(1));
        start = 1'b1; op = OP_MUL; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("ign_idle_busy", 64'(busy), 64'(0));
        chk("ign_z_held", 64'(z), 64'(12));
        repeat (40) @(negedge clk);
        chk("ign_no_queue", 64'(sbq.size()), 64'(0));

        // Reset in the middle of a divide aborts it with no done
        issue(OP_DIV, 32'd1000, 32'd7, 32'd0, 1'b0, 33, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_z", 64'(z), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        repeat (40) @(negedge clk);
        chk("midrst_still_idle", 64'(busy), 64'(0));
        run(OP_MUL, 32'd2, 32'd3, 32'd6, 1'b0, 33);

        repeat (3) @(negedge clk);
        chk("final_busy", 64'(busy), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
